// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scanner with leading-zero blanking,
// PWM dimming, a one-cycle ghost guard per slot and a per-frame snapshot of the value.
module seg7_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 25000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   disp_val,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  enable,
  output logic [6:0]            cathodes,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int SC_W = $clog2(SCAN_CYCLES);
  localparam int DI_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [SC_W-1:0]     r_sc;
  logic [DI_W-1:0]     r_di;
  logic [BRIGHT_W-1:0] r_pc;
  logic [4*DIGITS-1:0] r_snap_val;
  logic [DIGITS-1:0]   r_snap_dp;
  logic [DIGITS-1:0]   w_nz, w_live;
  logic [3:0]          w_nib;
  logic                w_sc_wrap, w_di_last, w_sup, w_on;
  // w_live[i]: some digit at or above i carries a nonzero nibble or a lit dp
  always_comb begin
    for (int i = 0; i < DIGITS; i++) w_nz[i] = (|r_snap_val[4*i +: 4]) | r_snap_dp[i];
    for (int i = 0; i < DIGITS; i++) w_live[i] = |(w_nz >> i);
  end
  assign w_sc_wrap = r_sc == SC_W'(SCAN_CYCLES - 1);
  assign w_di_last = r_di == DI_W'(DIGITS - 1);
  assign w_nib     = r_snap_val[{r_di, 2'b00} +: 4];
  assign w_sup     = blank_lz && r_di != '0 && !w_live[r_di];
  assign w_on      = enable && r_sc != '0 && !w_sup && (&brightness || r_pc < brightness);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc       <= '0;
      r_di       <= '0;
      r_pc       <= '0;
      r_snap_val <= '0;
      r_snap_dp  <= '0;
      an         <= '1;
      cathodes   <= '1;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_sc <= w_sc_wrap ? '0 : r_sc + SC_W'(1);
      if (w_sc_wrap) r_di <= w_di_last ? '0 : r_di + DI_W'(1);
      r_pc <= r_pc + BRIGHT_W'(1);
      if (r_sc == '0 && r_di == '0) begin
        r_snap_val <= disp_val;
        r_snap_dp  <= dp_in;
      end
      an         <= w_on ? ~(DIGITS'(1) << r_di) : '1;
      cathodes   <= w_on ? FONT[w_nib] : '1;
      dp         <= w_on ? ~r_snap_dp[r_di] : 1'b1;
      frame_done <= w_sc_wrap && w_di_last;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scoreboard bench; a frame-time reference model predicts every output cycle.
module tb_seg7_scan_ctrl;
  localparam int D = 4, S = 4, FR = D * S;
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] c;
    logic       dp;
    logic       fd;
  } exp_t;
  logic clk = 0, rst = 1, blank_lz = 0, enable = 1;
  logic [15:0] disp_val = '0;
  logic [3:0] dp_in = '0, brightness = '1;
  logic [6:0] cathodes;
  logic dp, frame_done;
  logic [3:0] an;
  exp_t q[$];
  int t = 0, total = 0, passed = 0;
  logic [15:0] m_v = '0;
  logic [3:0] m_d = '0;

  seg7_scan_ctrl #(.DIGITS(D), .SCAN_CYCLES(S), .BRIGHT_W(4)) dut (
    .clk(clk), .rst(rst), .disp_val(disp_val), .dp_in(dp_in), .blank_lz(blank_lz),
    .brightness(brightness), .enable(enable), .cathodes(cathodes), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s at t=%0d: got %0h, want %0h", n, t, a, e);
  endtask

  // Drives one cycle of inputs and pushes the response expected on the following cycle.
  task automatic step(input logic r, input logic [15:0] v, input logic [3:0] d,
                      input logic b, input logic [3:0] br, input logic e);
    exp_t x;
    int sc, di;
    logic sup, on;
    @(posedge clk);
    #1;
    rst = r; disp_val = v; dp_in = d; blank_lz = b; brightness = br; enable = e;
    if (r) begin
      x = '{an: 4'hF, c: 7'h7F, dp: 1'b1, fd: 1'b0};
      t = 0;
    end else begin
      if (t % FR == 0) begin
        m_v = v;
        m_d = d;
      end
      sc = t % S;
      di = (t / S) % D;
      sup = b && di > 0 && (m_v >> (4 * di)) == 0 && (m_d >> di) == 0;
      on = e && sc != 0 && !sup && (br == 4'hF || (t % 16) < int'(br));
      x.an = on ? ~(4'(1) << di) : 4'hF;
      x.c = on ? FONT[4'(m_v >> (4 * di))] : 7'h7F;
      x.dp = on ? !m_d[di] : 1'b1;
      x.fd = (t % FR) == FR - 1;
      t++;
    end
    q.push_back(x);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        @(negedge clk);
        chk("an", an, x.an);
        chk("cathodes", cathodes, x.c);
        chk("dp", dp, x.dp);
        chk("frame_done", frame_done, x.fd);
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic [3:0] d, br;
    logic b, e, r;
    repeat (3) step(1, 16'h0, 4'h0, 0, 4'hF, 1);
    repeat (2 * FR) step(0, 16'h12AF, 4'h0, 0, 4'hF, 1);
    repeat (5) step(0, 16'h12AF, 4'h0, 0, 4'hF, 1);
    repeat (3) step(1, 16'h12AF, 4'h0, 0, 4'hF, 1);
    repeat (FR + 2) step(0, 16'h12AF, 4'h5, 0, 4'hF, 1);
    repeat (2 * FR) step(0, 16'h0040, 4'h0, 1, 4'hF, 1);
    repeat (2 * FR) step(0, 16'h0040, 4'b1000, 1, 4'hF, 1);
    repeat (4 * FR) step(0, 16'h3C5E, 4'h2, 0, 4'd4, 1);
    repeat (2 * FR) step(0, 16'h3C5E, 4'h2, 0, 4'd0, 1);
    repeat (FR + 2 * S + 1) step(0, 16'h1111, 4'h0, 0, 4'hF, 1);
    repeat (2 * FR) step(0, 16'h2222, 4'h0, 0, 4'hF, 1);
    repeat (FR) step(0, 16'h9876, 4'hF, 0, 4'hF, 0);
    repeat (FR) step(0, 16'h9876, 4'hF, 0, 4'hF, 1);
    v = 16'h0; d = 4'h0; br = 4'hF; b = 1; e = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        v = 16'($urandom);
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) v &= ~(16'hF << (4 * k));
      end
      if ($urandom_range(0, 29) == 0) d = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0) br = 4'($urandom);
      if ($urandom_range(0, 49) == 0) b = 1'($urandom);
      if ($urandom_range(0, 99) == 0) e = !e;
      r = $urandom_range(0, 399) == 0;
      step(r, v, d, b, br, e);
    end
    step(0, v, d, b, br, e);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller for board debug output. It drives `DIGITS` common-anode digits from a packed hex value and has the following features:
- per-digit decimal points;
- optional leading-zero blanking;
- PWM brightness;
- a one-cycle inter-digit ghost guard;
- a frame-coherent snapshot of the displayed value.

It sits between the CPU's display register and the board pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned, legal 1..8.
- `SCAN_CYCLES`, 25000: clock cycles per digit slot, legal ≥ 4.
- `BRIGHT_W`, 4: width of the brightness control.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `disp_val`  in  4*DIGITS  hex nibbles, digit i = bits [4i+3:4i], digit 0 rightmost.
- `dp_in`  in  DIGITS  decimal point request per digit, 1 = lit.
- `blank_lz`  in  1  1 = suppress leading zeros.
- `brightness`  in  BRIGHT_W  PWM duty, 0 = dark, all-ones = full on.
- `enable`  in  1  0 = all anodes off, counters keep running.
- `cathodes`  out  7  segments g..a, active-low, registered.
- `dp`  out  1  decimal point segment, active-low, registered.
- `an`  out  DIGITS  digit anodes, active-low, one-hot-low or all-ones, registered.
- `frame_done`  out  1  one-cycle pulse after the last slot of each frame, registered.

## Operation
Counters and snapshot:
- Slot counter `sc` counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, digit index `di` increments 0..DIGITS-1 and wraps to 0.
  - DIGITS=1 keeps `di` at 0.
- Free-running PWM counter `pc` is BRIGHT_W bits wide, increments every cycle and wraps naturally.
- Snapshot register `snap` loads `disp_val` and `dp_in` in the cycle where sc=0 and di=0.
  - All display content for the whole frame comes from `snap`.
  - Mid-frame input changes never tear a frame.

Leading-zero blanking, with blank_lz=1:
- Digit i is suppressed when i>0, `snap` nibbles i..DIGITS-1 are all 0, and no `snap` dp bit in i..DIGITS-1 is set.
- Digit 0 is never suppressed.

Anode drive:
- Anode for `di` is asserted (0) only when all of these hold:
  - enable=1;
  - sc≠0, which is the ghost guard cycle;
  - the digit is not suppressed;
  - the PWM condition is true.
- PWM condition: brightness = all-ones, or `pc` < brightness.
- Otherwise all `an` bits are 1.

Segment drive:
- Decode uses the standard hex font, active-low, order g..a.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- When the anode is deasserted, `cathodes`=1111111 and `dp`=1.
- Otherwise `dp` = ~snap dp bit for `di`.

## Timing
Reset:
- While rst=1, at each clock edge: sc=0, di=0, pc=0, snap=0, an=all ones, cathodes=1111111, dp=1, frame_done=0.
- Reset mid-frame aborts the frame immediately; no frame_done is generated.

Frame start and latency:
- First cycle after rst deasserts is sc=0, di=0. The snapshot loads in that cycle.
- Registered outputs reflect the counter state of the previous cycle, a 1-cycle latency.
  - Example: the `an` pattern for slot (di, sc) is visible during the cycle when the counters hold (di, sc+1).
- The first displayable output for a slot appears at cycle sc=2 of that slot. Every slot's visible window is therefore preceded by one all-off cycle.

Frame period and `frame_done`:
- Frame period = DIGITS*SCAN_CYCLES cycles.
- `frame_done` is high for exactly one cycle: the cycle after the counters hold di=DIGITS-1, sc=SCAN_CYCLES-1, which coincides with sc=0, di=0 of the next frame.

Inputs:
- `brightness`, `enable` and `blank_lz` are sampled live every cycle and are not snapshotted.

## Test plan
- Reset check: assert rst for 3 cycles mid-scan -> an=all ones, cathodes=1111111, dp=1, frame_done=0. The first frame_done pulse arrives exactly DIGITS*SCAN_CYCLES cycles after release.
- Basic scan: DIGITS=4, SCAN_CYCLES=4, brightness=all ones, disp_val=16'h12AF, dp_in=0.
  - Expected sequence: an=1110 with cathodes=0001110 (F), then 1101 with 0001000 (A), then 1011 with 0100100 (2), then 0111 with 1111001 (1).
  - Each digit is lit for 3 cycles, separated by a 1-cycle all-ones guard.
- Leading zeros: disp_val=16'h0040.
  - blank_lz=1 -> digits 3 and 2 have anodes never asserted; digit 1 shows 4; digit 0 shows 0.
  - Setting dp_in=4'b1000 -> digit 3 shows 0 with dp=0.
- Brightness: SCAN_CYCLES=64, brightness=4 -> the asserted-anode count per slot equals the number of cycles with `pc`<4 among slot cycles 1..63. brightness=0 -> no anode ever asserted.
- Snapshot coherence: change disp_val from 16'h1111 to 16'h2222 during digit 2's slot -> digits 2 and 3 of the current frame still show 1, and the next frame shows all 2.
- Enable: enable=0 for one whole frame -> an=all ones throughout, while frame_done still pulses on schedule.
